regfile_wb_arbiter: RTL and testbench

//  Write-back side of the 32x32 register file: merges a single-cycle ALU result stream (A) and a

---
 rtl/regfile_wb_arbiter.sv | 88 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and buffered long-latency results onto one regfile write port, with a pending scoreboard
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [4:0]               a_reg,
  input  logic [31:0]              a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_reg,
  input  logic [31:0]              b_data,
  input  logic                     iss_valid,
  input  logic [4:0]               iss_reg,
  output logic                     wen,
  output logic [4:0]               wreg,
  output logic [31:0]              wdata,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   b_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [36:0]    mem_q [DEPTH];
  logic [36:0]    head_e;
  logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  st_q, st_d;
  logic           wen_q, wen_d;
  logic [4:0]     wreg_q, wreg_d;
  logic [31:0]    wdata_q, wdata_d, pend_q, pend_d;
  logic           nonempty, force_b, a_take, a_wr, pop, push;
  assign a_ready = !force_b;
  assign b_ready = cnt_q != CW'(DEPTH);
  assign wen     = wen_q;
  assign wreg    = wreg_q;
  assign wdata   = wdata_q;
  assign pending = pend_q;
  assign b_count = cnt_q;
  // slot arbitration, FIFO pointer/occupancy and scoreboard next state
  always_comb begin
    nonempty = cnt_q != '0;
    force_b  = (st_q == SW'(STARVE_MAX)) && nonempty;
    a_take   = a_valid && !force_b;
    a_wr     = a_take && a_reg != 5'd0;
    pop      = !a_take && nonempty;
    push     = b_valid && b_ready && b_reg != 5'd0;
    head_e   = mem_q[head_q];
    head_d   = pop ? head_q + AW'(1) : head_q;
    tail_d   = push ? tail_q + AW'(1) : tail_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    st_d     = (pop || !nonempty) ? '0 : a_take ? st_q + SW'(1) : st_q;
    wen_d    = a_wr || pop;
    wreg_d   = a_wr ? a_reg : pop ? head_e[36:32] : wreg_q;
    wdata_d  = a_wr ? a_data : pop ? head_e[31:0] : wdata_q;
    pend_d   = (pend_q & ~({31'd0, wen_q} << wreg_q)) | ({31'd0, iss_valid} << iss_reg);
    pend_d[0] = 1'b0;
  end
  // control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      st_q    <= '0;
      wen_q   <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      pend_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      wen_q   <= wen_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
    end
  end
  // FIFO storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= {b_reg, b_data};
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus randomized traffic against a queue-based model
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  logic clk = 0, reset = 1;
  logic a_valid = 0, b_valid = 0, iss_valid = 0;
  logic [4:0] a_reg = 0, b_reg = 0, iss_reg = 0;
  logic [31:0] a_data = 0, b_data = 0;
  logic a_ready, b_ready, wen;
  logic [4:0] wreg;
  logic [31:0] wdata, pending;
  logic [2:0] b_count;
  int pass = 0, total = 0;
  logic [31:0] rf [32];
  logic r0w = 0;
  logic [36:0] mq [$];
  int mst = 0;
  logic mwen = 0;
  logic [4:0] mwreg = 0;
  logic [31:0] mwdata = 0, mpend = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .iss_valid(iss_valid), .iss_reg(iss_reg),
    .wen(wen), .wreg(wreg), .wdata(wdata), .pending(pending), .b_count(b_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wen) begin
    rf[wreg] <= wdata;
    if (wreg == 5'd0) r0w <= 1'b1;
  end

  function automatic logic m_ar();
    return !(mst == 3 && mq.size() != 0);
  endfunction

  task automatic model_step();
    int n;
    logic take;
    logic [36:0] e;
    if (reset) begin
      mq.delete(); mst = 0; mwen = 0; mwreg = 0; mwdata = 0; mpend = 0;
      return;
    end
    n = mq.size();
    take = a_valid && m_ar();
    if (mwen) mpend[mwreg] = 1'b0;
    if (iss_valid) mpend[iss_reg] = 1'b1;
    mpend[0] = 1'b0;
    if (take) begin
      mwen = a_reg != 0;
      if (a_reg != 0) begin mwreg = a_reg; mwdata = a_data; end
      mst = (n != 0) ? mst + 1 : 0;
    end else if (n != 0) begin
      e = mq.pop_front();
      mwen = 1; mwreg = e[36:32]; mwdata = e[31:0]; mst = 0;
    end else begin
      mwen = 0; mst = 0;
    end
    if (b_valid && n < 4 && b_reg != 0) mq.push_back({b_reg, b_data});
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; iss_valid = 0; a_reg = 0; b_reg = 0; iss_reg = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle(); cyc(); reset = 0;
    total++; if ({wen, wreg, wdata} !== 38'd0) $display("FAIL reset_out got %0b/%0d/%h want 0", wen, wreg, wdata); else pass++;
    total++; if ({b_count, pending} !== 35'd0) $display("FAIL reset_state got cnt=%0d pend=%h want 0", b_count, pending); else pass++;
    total++; if ({a_ready, b_ready} !== 2'b11) $display("FAIL reset_ready got %b want 11", {a_ready, b_ready}); else pass++;
  endtask

  task automatic test_reset_midstream();
    a_valid = 1; a_reg = 5; a_data = 1; b_valid = 1; b_reg = 3; b_data = 32'h33;
    iss_valid = 1; iss_reg = 1; cyc();
    iss_reg = 2; cyc();
    iss_valid = 0; cyc();
    total++; if (b_count !== 3'd3) $display("FAIL mid_count got %0d want 3", b_count); else pass++;
    total++; if (pending !== 32'h6) $display("FAIL mid_pending got %h want 6", pending); else pass++;
    reset = 1; idle(); cyc(); reset = 0;
    total++; if ({wen, b_count, pending} !== 36'd0) $display("FAIL mid_reset got wen=%0b cnt=%0d pend=%h want 0", wen, b_count, pending); else pass++;
    total++; if ({a_ready, b_ready} !== 2'b11) $display("FAIL mid_ready got %b want 11", {a_ready, b_ready}); else pass++;
  endtask

  task automatic test_alu();
    a_valid = 1; a_reg = 5; a_data = 32'h1234_5678; cyc(); idle();
    total++; if ({wen, wreg, wdata} !== {1'b1, 5'd5, 32'h1234_5678}) $display("FAIL alu_write got %0b/%0d/%h want 1/5/12345678", wen, wreg, wdata); else pass++;
    cyc();
    total++; if (rf[5] !== 32'h1234_5678 || wen !== 1'b0) $display("FAIL alu_rf got r5=%h wen=%0b want 12345678/0", rf[5], wen); else pass++;
  endtask

  task automatic test_b_latency();
    b_valid = 1; b_reg = 7; b_data = 32'hDEAD_BEEF; cyc(); idle();
    total++; if ({wen, b_count} !== {1'b0, 3'd1}) $display("FAIL b_push got wen=%0b cnt=%0d want 0/1", wen, b_count); else pass++;
    cyc();
    total++; if ({wen, wreg, wdata, b_count} !== {1'b1, 5'd7, 32'hDEAD_BEEF, 3'd0}) $display("FAIL b_pop got %0b/%0d/%h cnt=%0d want 1/7/deadbeef/0", wen, wreg, wdata, b_count); else pass++;
    cyc();
    total++; if (rf[7] !== 32'hDEAD_BEEF) $display("FAIL b_rf got %h want deadbeef", rf[7]); else pass++;
  endtask

  task automatic test_starve();
    b_valid = 1; b_reg = 8; b_data = 32'hB0B0;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_reg = 10; a_data = 32'hA0 + i;
      total++; if (a_ready !== 1'b1) $display("FAIL starve_ready%0d got %0b want 1", i, a_ready); else pass++;
      cyc(); b_valid = 0;
      total++; if ({wen, wreg, wdata} !== {1'b1, 5'd10, 32'hA0 + i}) $display("FAIL starve_a%0d got %0b/%0d/%h want 1/10/%h", i, wen, wreg, wdata, 32'hA0 + i); else pass++;
    end
    a_data = 32'hA4;
    total++; if (a_ready !== 1'b0) $display("FAIL starve_force got a_ready=%0b want 0", a_ready); else pass++;
    cyc();
    total++; if ({wen, wreg, wdata, b_count} !== {1'b1, 5'd8, 32'hB0B0, 3'd0}) $display("FAIL starve_b got %0b/%0d/%h cnt=%0d want 1/8/b0b0/0", wen, wreg, wdata, b_count); else pass++;
    total++; if (a_ready !== 1'b1) $display("FAIL starve_resume_ready got %0b want 1", a_ready); else pass++;
    cyc(); idle();
    total++; if ({wen, wreg, wdata} !== {1'b1, 5'd10, 32'hA4}) $display("FAIL starve_resume got %0b/%0d/%h want 1/10/a4", wen, wreg, wdata); else pass++;
    cyc();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_reg = 11; a_data = i; b_valid = 1; b_reg = 5'(12 + i); b_data = 32'hC0 + i;
      cyc();
    end
    total++; if ({b_count, b_ready, a_ready} !== {3'd4, 1'b0, 1'b0}) $display("FAIL full_state got cnt=%0d br=%0b ar=%0b want 4/0/0", b_count, b_ready, a_ready); else pass++;
    b_reg = 16; b_data = 32'hC4; cyc();
    total++; if ({wen, wreg, wdata, b_count} !== {1'b1, 5'd12, 32'hC0, 3'd3}) $display("FAIL full_pop got %0b/%0d/%h cnt=%0d want 1/12/c0/3", wen, wreg, wdata, b_count); else pass++;
    cyc(); idle();
    total++; if ({wen, wreg, b_count} !== {1'b1, 5'd11, 3'd4}) $display("FAIL full_push5 got %0b/%0d cnt=%0d want 1/11/4", wen, wreg, b_count); else pass++;
    for (int i = 1; i < 5; i++) begin
      cyc();
      total++; if ({wen, wreg, wdata} !== {1'b1, 5'(12 + i), 32'hC0 + i}) $display("FAIL full_order%0d got %0b/%0d/%h want 1/%0d/%h", i, wen, wreg, wdata, 12 + i, 32'hC0 + i); else pass++;
    end
    total++; if (b_count !== 3'd0) $display("FAIL full_drain got %0d want 0", b_count); else pass++;
  endtask

  task automatic test_scoreboard();
    iss_valid = 1; iss_reg = 9; cyc(); idle();
    total++; if (pending[9] !== 1'b1) $display("FAIL sb_set got %0b want 1", pending[9]); else pass++;
    b_valid = 1; b_reg = 9; b_data = 32'h9; cyc(); idle(); cyc();
    total++; if ({wen, wreg, pending[9]} !== {1'b1, 5'd9, 1'b1}) $display("FAIL sb_bwrite got %0b/%0d p=%0b want 1/9/1", wen, wreg, pending[9]); else pass++;
    iss_valid = 1; iss_reg = 9; cyc(); idle();
    total++; if (pending[9] !== 1'b1) $display("FAIL sb_setwins got %0b want 1", pending[9]); else pass++;
    a_valid = 1; a_reg = 9; a_data = 32'h99; cyc(); idle(); cyc();
    total++; if (pending !== 32'd0) $display("FAIL sb_clear got %h want 0", pending); else pass++;
    a_valid = 1; a_reg = 0; a_data = 32'h55; iss_valid = 1; iss_reg = 0;
    total++; if (a_ready !== 1'b1) $display("FAIL sb_a0_ready got %0b want 1", a_ready); else pass++;
    cyc(); idle();
    total++; if ({wen, pending} !== 33'd0) $display("FAIL sb_a0 got wen=%0b pend=%h want 0/0", wen, pending); else pass++;
    b_valid = 1; b_reg = 0; b_data = 32'h66; cyc(); idle();
    total++; if (b_count !== 3'd0) $display("FAIL sb_b0_count got %0d want 0", b_count); else pass++;
    cyc();
    total++; if (wen !== 1'b0 || r0w !== 1'b0) $display("FAIL sb_r0 got wen=%0b r0w=%0b want 0/0", wen, r0w); else pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset = $urandom_range(99) == 0;
      if (!(a_valid && !m_ar()) || reset) begin
        a_valid = $urandom_range(2) != 0;
        a_reg = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
        a_data = $urandom;
      end
      b_valid = $urandom_range(1);
      b_reg = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      b_data = $urandom;
      iss_valid = $urandom_range(1);
      iss_reg = 5'($urandom_range(31));
      cyc();
      total++;
      if ({wen, wreg, wdata, pending, b_count, a_ready, b_ready} !== {mwen, mwreg, mwdata, mpend, 3'(mq.size()), m_ar(), mq.size() < 4})
        $display("FAIL rand%0d got wen=%0b wreg=%0d wdata=%h pend=%h cnt=%0d ar=%0b br=%0b want %0b/%0d/%h/%h/%0d/%0b/%0b",
                 i, wen, wreg, wdata, pending, b_count, a_ready, b_ready, mwen, mwreg, mwdata, mpend, mq.size(), m_ar(), mq.size() < 4);
      else pass++;
    end
    reset = 0; idle(); cyc();
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_alu();
    test_b_latency();
    test_starve();
    test_full();
    test_scoreboard();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
